// File: rtl/traffic_signal_monitor.sv
// Conflict and sequence monitor for the two-approach signal bus.
// Flags the first fault with a code, counts faults, and drives a flashing-red fail-safe output.
module traffic_signal_monitor #(
    parameter int unsigned MIN_YELLOW   = 5,
    parameter int unsigned WATCHDOG_MAX = 127,
    parameter int unsigned FLASH_HALF   = 8,
    parameter int unsigned CNT_W        = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] T1,
    input  logic [1:0] T2,
    input  logic       T1_WALK,
    input  logic       T2_WALK,
    input  logic       buzzer,
    input  logic       preempt,
    input  logic       clear_fault,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [7:0] fault_count,
    output logic       flash
);

    localparam logic [1:0] COL_G = 2'b00;
    localparam logic [1:0] COL_Y = 2'b01;
    localparam logic [1:0] COL_R = 2'b10;
    localparam logic [1:0] COL_X = 2'b11;

    localparam logic [CNT_W-1:0] CNT_ZERO   = '0;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] MIN_Y      = CNT_W'(MIN_YELLOW);
    localparam logic [CNT_W-1:0] WD_LIMIT   = CNT_W'(WATCHDOG_MAX);
    localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_HALF - 1);

    logic             prev_valid;
    logic             prev_preempt;
    logic [1:0]       prev_t1;
    logic [1:0]       prev_t2;
    logic [CNT_W-1:0] dwell1;
    logic [CNT_W-1:0] dwell2;
    logic [CNT_W-1:0] watchdog;
    logic [CNT_W-1:0] flash_cnt;

    logic             seq_en;
    logic             c_conflict, c_encoding, c_walk, c_seq, c_short, c_stuck, c_buzz;
    logic [2:0]       det_code;
    logic             det_any;
    logic             do_latch;
    logic             do_clear;
    logic [CNT_W-1:0] dwell1_next;
    logic [CNT_W-1:0] dwell2_next;
    logic [CNT_W-1:0] watchdog_next;

    // Evaluate every fault condition on the current bus against the registered history.
    always_comb begin
        // Sequence rules are only meaningful with valid history and no preemption on either side.
        seq_en     = prev_valid && !preempt && !prev_preempt;
        c_conflict = (T1 == COL_G || T1 == COL_Y) && (T2 == COL_G || T2 == COL_Y);
        c_encoding = (T1 == COL_X) || (T2 == COL_X);
        c_walk     = (T1_WALK || T2_WALK) && !(T1 == COL_R && T2 == COL_R);
        c_seq      = seq_en && (((prev_t1 == COL_G) && (T1 == COL_R)) ||
                                ((prev_t1 == COL_Y) && (T1 == COL_G)) ||
                                ((prev_t2 == COL_G) && (T2 == COL_R)) ||
                                ((prev_t2 == COL_Y) && (T2 == COL_G)));
        c_short    = seq_en && (((prev_t1 == COL_Y) && (T1 == COL_R) && (dwell1 < MIN_Y)) ||
                                ((prev_t2 == COL_Y) && (T2 == COL_R) && (dwell2 < MIN_Y)));
        c_stuck    = (watchdog >= WD_LIMIT);
        c_buzz     = buzzer && !(T1_WALK && T2_WALK);

        if (c_conflict)      det_code = 3'd1;
        else if (c_encoding) det_code = 3'd2;
        else if (c_walk)     det_code = 3'd3;
        else if (c_seq)      det_code = 3'd4;
        else if (c_short)    det_code = 3'd5;
        else if (c_stuck)    det_code = 3'd6;
        else if (c_buzz)     det_code = 3'd7;
        else                 det_code = 3'd0;

        det_any  = (det_code != 3'd0);
        do_latch = !fault && det_any;
        do_clear = fault && clear_fault && !det_any;
    end

    // Next values for the saturating yellow-dwell and stuck-bus counters.
    always_comb begin
        dwell1_next = CNT_ZERO;
        dwell2_next = CNT_ZERO;
        if (T1 == COL_Y) dwell1_next = (dwell1 == CNT_MAX) ? dwell1 : dwell1 + CNT_ONE;
        if (T2 == COL_Y) dwell2_next = (dwell2 == CNT_MAX) ? dwell2 : dwell2 + CNT_ONE;
        if ({T1, T2} == {prev_t1, prev_t2}) begin
            watchdog_next = (watchdog == CNT_MAX) ? watchdog : watchdog + CNT_ONE;
        end else begin
            watchdog_next = CNT_ZERO;
        end
    end

    // Bus history and counters; a successful clear restarts history as if freshly reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_valid   <= 1'b0;
            prev_preempt <= 1'b0;
            prev_t1      <= COL_R;
            prev_t2      <= COL_R;
            dwell1       <= CNT_ZERO;
            dwell2       <= CNT_ZERO;
            watchdog     <= CNT_ZERO;
        end else begin
            prev_valid   <= !do_clear;
            prev_preempt <= preempt;
            prev_t1      <= T1;
            prev_t2      <= T2;
            dwell1       <= do_clear ? CNT_ZERO : dwell1_next;
            dwell2       <= do_clear ? CNT_ZERO : dwell2_next;
            watchdog     <= do_clear ? CNT_ZERO : watchdog_next;
        end
    end

    // Fault latch, first-fault code, saturating count and fail-safe flash generator.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault       <= 1'b0;
            fault_code  <= 3'd0;
            fault_count <= 8'd0;
            flash       <= 1'b0;
            flash_cnt   <= CNT_ZERO;
        end else if (do_latch) begin
            fault       <= 1'b1;
            fault_code  <= det_code;
            fault_count <= (fault_count == 8'hFF) ? fault_count : fault_count + 8'd1;
            flash       <= 1'b1;
            flash_cnt   <= CNT_ZERO;
        end else if (do_clear) begin
            fault       <= 1'b0;
            fault_code  <= 3'd0;
            flash       <= 1'b0;
            flash_cnt   <= CNT_ZERO;
        end else if (fault) begin
            if (flash_cnt == FLASH_LAST) begin
                flash     <= !flash;
                flash_cnt <= CNT_ZERO;
            end else begin
                flash_cnt <= flash_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_traffic_signal_monitor.sv
// Self-checking bench for traffic_signal_monitor: directed scenarios plus randomized bus traffic,
// all compared every cycle against a rule-level reference model.
module tb_traffic_signal_monitor;

    localparam int MIN_YELLOW   = 5;
    localparam int WATCHDOG_MAX = 127;
    localparam int FLASH_HALF   = 8;

    localparam logic [1:0] G = 2'b00;
    localparam logic [1:0] Y = 2'b01;
    localparam logic [1:0] R = 2'b10;
    localparam logic [1:0] X = 2'b11;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] T1, T2;
    logic       T1_WALK, T2_WALK, buzzer, preempt, clear_fault;
    logic       fault;
    logic [2:0] fault_code;
    logic [7:0] fault_count;
    logic       flash;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    traffic_signal_monitor #(
        .MIN_YELLOW  (MIN_YELLOW),
        .WATCHDOG_MAX(WATCHDOG_MAX),
        .FLASH_HALF  (FLASH_HALF),
        .CNT_W       (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .T1         (T1),
        .T2         (T2),
        .T1_WALK    (T1_WALK),
        .T2_WALK    (T2_WALK),
        .buzzer     (buzzer),
        .preempt    (preempt),
        .clear_fault(clear_fault),
        .fault      (fault),
        .fault_code (fault_code),
        .fault_count(fault_count),
        .flash      (flash)
    );

    // Reference model: what has been seen on the bus, in plain integers.
    typedef struct packed {
        int p1;      // last sampled colours
        int p2;
        bit pv;      // history is trustworthy
        bit pp;      // preempt in the last sample
        int y1;      // length of the current yellow run so far
        int y2;
        int stable;  // consecutive samples identical to their predecessor
        bit fault;
        int code;
        int count;
        int age;     // cycles since the fault was latched
    } mstate_t;

    mstate_t m;

    function automatic mstate_t mreset();
        mstate_t s;
        s = '0;
        s.p1 = 2;
        s.p2 = 2;
        return s;
    endfunction

    function automatic bit skipped(int p, int t);
        return (p == 0 && t == 2) || (p == 1 && t == 0);
    endfunction

    function automatic int detect(mstate_t s, int t1, int t2, bit w1, bit w2, bit bz, bit pre);
        bit gate;
        gate = s.pv && !pre && !s.pp;
        if (t1 < 2 && t2 < 2) return 1;
        if (t1 == 3 || t2 == 3) return 2;
        if ((w1 || w2) && !(t1 == 2 && t2 == 2)) return 3;
        if (gate && (skipped(s.p1, t1) || skipped(s.p2, t2))) return 4;
        if (gate && ((s.p1 == 1 && t1 == 2 && s.y1 < MIN_YELLOW) ||
                     (s.p2 == 1 && t2 == 2 && s.y2 < MIN_YELLOW))) return 5;
        if (s.stable >= WATCHDOG_MAX) return 6;
        if (bz && !(w1 && w2)) return 7;
        return 0;
    endfunction

    function automatic mstate_t mstep(mstate_t s, int t1, int t2, bit w1, bit w2, bit bz,
                                      bit pre, bit clr);
        mstate_t n;
        int      code;
        bit      cleared;
        n       = s;
        cleared = 0;
        code    = detect(s, t1, t2, w1, w2, bz, pre);
        if (!s.fault && code != 0) begin
            n.fault = 1;
            n.code  = code;
            n.count = (s.count < 255) ? s.count + 1 : 255;
            n.age   = 0;
        end else if (s.fault && clr && code == 0) begin
            n.fault = 0;
            n.code  = 0;
            n.age   = 0;
            cleared = 1;
        end else if (s.fault) begin
            n.age = s.age + 1;
        end
        n.y1     = cleared ? 0 : ((t1 == 1) ? s.y1 + 1 : 0);
        n.y2     = cleared ? 0 : ((t2 == 1) ? s.y2 + 1 : 0);
        n.stable = cleared ? 0 : ((t1 == s.p1 && t2 == s.p2) ? s.stable + 1 : 0);
        n.p1     = t1;
        n.p2     = t2;
        n.pv     = !cleared;
        n.pp     = pre;
        return n;
    endfunction

    function automatic bit mflash(mstate_t s);
        return s.fault && (((s.age / FLASH_HALF) % 2) == 0);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) m <= mreset();
        else m <= mstep(m, int'(T1), int'(T2), T1_WALK, T2_WALK, buzzer, preempt, clear_fault);
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if (fault !== m.fault || fault_code !== 3'(m.code) || fault_count !== 8'(m.count) ||
                flash !== mflash(m)) begin
                errors++;
                $display("FAIL cycle t=%0t dut fault=%0b code=%0d count=%0d flash=%0b required fault=%0b code=%0d count=%0d flash=%0b",
                         $time, fault, fault_code, fault_count, flash,
                         m.fault, m.code, m.count, mflash(m));
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] t1, input logic [1:0] t2, input logic w1,
                         input logic w2, input logic bz, input logic pre, input logic clr,
                         input int n);
        repeat (n) begin
            T1 = t1; T2 = t2; T1_WALK = w1; T2_WALK = w2;
            buzzer = bz; preempt = pre; clear_fault = clr;
            @(negedge clk);
        end
    endtask

    task automatic normal_loop();
        drive(G, R, 0, 0, 0, 0, 0, 31);
        drive(Y, R, 0, 0, 0, 0, 0, 6);
        drive(R, R, 1, 1, 0, 0, 0, 56);
        drive(R, R, 1, 1, 1, 0, 0, 5);
        drive(R, G, 0, 0, 0, 0, 0, 31);
        drive(R, Y, 0, 0, 0, 0, 0, 6);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] rt1, rt2;
        logic       rw, rbz, rpre;
        int         ph, left, r;

        reset = 1'b1;
        T1 = R; T2 = R; T1_WALK = 0; T2_WALK = 0;
        buzzer = 0; preempt = 0; clear_fault = 0;
        repeat (3) @(negedge clk);
        check("reset_fault", int'(fault), 0);
        check("reset_code", int'(fault_code), 0);
        check("reset_count", int'(fault_count), 0);
        check("reset_flash", int'(flash), 0);
        reset = 1'b0;

        repeat (3) normal_loop();
        check("normal_fault", int'(fault), 0);
        check("normal_count", int'(fault_count), 0);

        // Conflict, then flash half-period.
        drive(G, R, 0, 0, 0, 0, 0, 10);
        drive(G, G, 0, 0, 0, 0, 0, 1);
        check("conflict_fault", int'(fault), 1);
        check("conflict_code", int'(fault_code), 1);
        check("conflict_count", int'(fault_count), 1);
        check("conflict_flash", int'(flash), 1);
        drive(G, R, 0, 0, 0, 0, 0, 7);
        check("flash_hold", int'(flash), 1);
        drive(G, R, 0, 0, 0, 0, 0, 1);
        check("flash_toggle", int'(flash), 0);

        // Clear blocked by a live condition, then a legal clear.
        drive(X, R, 0, 0, 0, 0, 1, 1);
        check("clear_blocked_fault", int'(fault), 1);
        check("clear_blocked_code", int'(fault_code), 1);
        drive(G, R, 0, 0, 0, 0, 1, 1);
        check("clear_fault", int'(fault), 0);
        check("clear_code", int'(fault_code), 0);
        check("clear_flash", int'(flash), 0);
        check("clear_count_kept", int'(fault_count), 1);

        // Short yellow, then the same under preemption.
        drive(G, R, 0, 0, 0, 0, 0, 4);
        drive(Y, R, 0, 0, 0, 0, 0, 3);
        drive(R, R, 0, 0, 0, 0, 0, 1);
        check("short_yellow_code", int'(fault_code), 5);
        check("short_yellow_count", int'(fault_count), 2);
        drive(R, R, 0, 0, 0, 0, 1, 1);
        check("short_yellow_clear", int'(fault), 0);
        drive(G, R, 0, 0, 0, 1, 0, 4);
        drive(Y, R, 0, 0, 0, 1, 0, 3);
        drive(R, R, 0, 0, 0, 1, 0, 2);
        check("preempt_short_yellow", int'(fault), 0);
        drive(R, R, 0, 0, 0, 0, 0, 2);

        // Skipped yellow with a walk in the same cycle: walk wins.
        drive(G, R, 0, 0, 0, 0, 0, 3);
        drive(R, G, 1, 0, 0, 0, 0, 1);
        check("walk_code", int'(fault_code), 3);
        check("walk_count", int'(fault_count), 3);
        drive(R, G, 0, 0, 0, 0, 0, 2);
        drive(R, G, 0, 0, 0, 0, 1, 1);
        check("walk_clear", int'(fault), 0);

        // Stuck bus.
        drive(R, Y, 0, 0, 0, 0, 0, 6);
        drive(R, R, 1, 1, 0, 0, 0, 128);
        check("stuck_early", int'(fault), 0);
        drive(R, R, 1, 1, 0, 0, 0, 1);
        check("stuck_fault", int'(fault), 1);
        check("stuck_code", int'(fault_code), 6);
        check("stuck_count", int'(fault_count), 4);

        // Asynchronous reset mid-fault, no clock edge in between.
        #2;
        reset = 1'b1;
        #1;
        check("async_fault", int'(fault), 0);
        check("async_code", int'(fault_code), 0);
        check("async_count", int'(fault_count), 0);
        check("async_flash", int'(flash), 0);
        @(negedge clk);
        reset = 1'b0;

        // Fault count saturation.
        repeat (260) begin
            drive(X, R, 0, 0, 0, 0, 0, 1);
            drive(R, R, 0, 0, 0, 0, 1, 1);
        end
        check("count_saturate", int'(fault_count), 255);
        check("count_saturate_fault", int'(fault), 0);

        // Randomized traffic: legal phase walk with injected glitches, preempt and clears.
        ph = 5; left = 0; rpre = 0;
        for (int i = 0; i < 3000; i++) begin
            if (left == 0) begin
                ph = (ph + 1) % 6;
                if (ph == 1 || ph == 5) left = $urandom_range(3, 7);
                else if (ph == 2 && $urandom_range(0, 19) == 0) left = 140;
                else left = $urandom_range(2, 20);
            end
            left--;
            case (ph)
                0: begin rt1 = G; rt2 = R; rw = 0; rbz = 0; end
                1: begin rt1 = Y; rt2 = R; rw = 0; rbz = 0; end
                2: begin rt1 = R; rt2 = R; rw = 1; rbz = 0; end
                3: begin rt1 = R; rt2 = R; rw = 1; rbz = 1; end
                4: begin rt1 = R; rt2 = G; rw = 0; rbz = 0; end
                default: begin rt1 = R; rt2 = Y; rw = 0; rbz = 0; end
            endcase
            r = $urandom_range(0, 99);
            if (r < 3) rt1 = 2'($urandom_range(0, 3));
            else if (r < 6) rt2 = 2'($urandom_range(0, 3));
            else if (r < 8) rw = !rw;
            else if (r < 10) rbz = !rbz;
            if ($urandom_range(0, 49) == 0) rpre = !rpre;
            drive(rt1, rt2, rw, rw, rbz, rpre, ($urandom_range(0, 9) == 0), 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
